// File: rtl/convertidor_pulso_multi_if.sv
// Button-to-pulse converter bundle: raw buttons and mode in,
// debounced levels and event pulses out.
interface convertidor_pulso_multi_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] in;
  logic [1:0]      mode;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] pulse;
  logic            any_pulse;

  modport master (
    output in, mode,
    input  level, pulse, any_pulse
  );

  modport slave (
    input  in, mode,
    output level, pulse, any_pulse
  );
endinterface

// File: rtl/convertidor_pulso_multi.sv
// N-channel button synchroniser, debouncer and pulse generator
// with press/release/both/auto-repeat event selection.
module convertidor_pulso_multi #(
  parameter int N_CH       = 4,
  parameter int DEB_CYC    = 250000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000
) (
  input logic                  clk,
  input logic                  rst,
  convertidor_pulso_multi_if.slave bus
);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int RMAX = (REP_DELAY > REP_PERIOD) ?
                        REP_DELAY : REP_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REP_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_t;

  logic [N_CH-1:0] level;
  logic [N_CH-1:0] pulse;
  logic            rep_mode;

  assign rep_mode = (bus.mode == 2'b11);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          lvl;
    logic [DW-1:0] cnt;
    logic          acc;
    logic          rise;
    logic          fall;
    logic          stop;
    logic          ev;
    logic          rep;
    logic          pls;
    rep_t          st;
    rep_t          st_n;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_n;

    assign acc  = (s2 != lvl) && (cnt == DEB_LAST);
    assign rise = acc & s2;
    assign fall = acc & ~s2;
    // A release accepted this edge must also silence the repeat.
    assign stop = ~lvl | ~rep_mode | fall;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        lvl <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= bus.in[i];
        s2 <= s1;
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (acc) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st   <= IDLE;
        rcnt <= '0;
        pls  <= 1'b0;
      end else begin
        st   <= st_n;
        rcnt <= rcnt_n;
        pls  <= ev | rep;
      end
    end

    always_comb begin
      ev = 1'b0;
      unique case (bus.mode)
        2'b01:   ev = fall;
        2'b10:   ev = acc;
        default: ev = rise;
      endcase
    end

    always_comb begin
      st_n   = st;
      rcnt_n = rcnt;
      rep    = 1'b0;
      unique case (st)
        IDLE: begin
          if (rise && rep_mode) begin
            st_n   = DELAY;
            rcnt_n = '0;
          end
        end
        DELAY: begin
          if (stop) begin
            st_n   = IDLE;
            rcnt_n = '0;
          end else if (rcnt == DLY_LAST) begin
            rep    = 1'b1;
            st_n   = REPEAT;
            rcnt_n = '0;
          end else begin
            rcnt_n = rcnt + RW'(1);
          end
        end
        REPEAT: begin
          if (stop) begin
            st_n   = IDLE;
            rcnt_n = '0;
          end else if (rcnt == PER_LAST) begin
            rep    = 1'b1;
            rcnt_n = '0;
          end else begin
            rcnt_n = rcnt + RW'(1);
          end
        end
        default: begin
          st_n   = IDLE;
          rcnt_n = '0;
        end
      endcase
    end

    assign level[i] = lvl;
    assign pulse[i] = pls;
  end

  assign bus.level     = level;
  assign bus.pulse     = pulse;
  assign bus.any_pulse = |pulse;
endmodule
